// File: rtl/cordic_pkg.sv
// Shared constants, quadrant type and arithmetic helpers for the CORDIC phase front end.
package cordic_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned PROD_W     = 32;
  localparam int unsigned ANG_SHIFT  = 14;
  localparam int unsigned GAIN_SHIFT = 15;

  localparam logic signed [PROD_W-1:0] HALF_PI_Q14 = 32'sd25736;
  localparam logic signed [PROD_W-1:0] INV_K_Q15   = 32'sd19898;
  localparam logic signed [PROD_W-1:0] ANG_ROUND   = 32'sd8192;
  localparam logic signed [PROD_W-1:0] GAIN_ROUND  = 32'sd16384;
  localparam logic [DATA_W-1:0]        QUAD_OFFSET = 16'h2000;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // Two's-complement negation that maps the most negative value to the most positive.
  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] res;
    if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res = -v;
    end
    return res;
  endfunction

  // Multiply by 1/K (Q1.15) with round-half-up, cancelling the CORDIC gain.
  function automatic logic signed [DATA_W-1:0] scale_inv_k(input logic signed [DATA_W-1:0] v);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(v) * INV_K_Q15 + GAIN_ROUND;
    return DATA_W'(prod >>> GAIN_SHIFT);
  endfunction

endpackage

// File: rtl/cordic_valid_delay.sv
// Parameterised-depth valid shift register with synchronous clear; exposes every tap.
module cordic_valid_delay #(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic [DEPTH-1:0] o_pipe
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_pipe = r_pipe;

endmodule

// File: rtl/cordic_phase_frontend.sv
// Quadrant pre-rotation and Q2.14 angle conversion ahead of the CORDIC rotator, plus valid tracking.
// Optional 1/K gain compensation on x/y is enabled with `define CORDIC_GAIN_COMP_EN.
module cordic_phase_frontend
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic        [WIDTH-1:0] phase_in,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] angle_out,
  output logic                    out_valid,
  output logic                    res_valid,
  output logic                    busy
);

  localparam int unsigned FE_DEPTH  = 2;
  localparam int unsigned ROT_DEPTH = STAGES + 1;

  logic [WIDTH-1:0]        w_p;
  quad_t                   w_q;
  logic signed [WIDTH-1:0] w_resid;

  quad_t                   r_q;
  logic signed [WIDTH-1:0] r_resid;
  logic signed [WIDTH-1:0] r_xa;
  logic signed [WIDTH-1:0] r_ya;

  logic signed [WIDTH-1:0]  w_x_rot;
  logic signed [WIDTH-1:0]  w_y_rot;
  logic signed [WIDTH-1:0]  w_x_b;
  logic signed [WIDTH-1:0]  w_y_b;
  logic signed [PROD_W-1:0] w_ang_prod;
  logic signed [WIDTH-1:0]  w_angle;

  logic signed [WIDTH-1:0] r_x_out;
  logic signed [WIDTH-1:0] r_y_out;
  logic signed [WIDTH-1:0] r_angle;

  logic [FE_DEPTH-1:0]  w_fe_pipe;
  logic [ROT_DEPTH-1:0] w_rot_pipe;

  // Quadrant from the offset phase; residual is the offset phase's low bits re-centred on zero.
  assign w_p     = phase_in + QUAD_OFFSET;
  assign w_q     = quad_t'(w_p[WIDTH-1 -: 2]);
  assign w_resid = signed'({2'b00, w_p[WIDTH-3:0]} - QUAD_OFFSET);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= QUAD_0;
      r_resid <= '0;
      r_xa    <= '0;
      r_ya    <= '0;
    end else if (in_valid) begin
      r_q     <= w_q;
      r_resid <= w_resid;
      r_xa    <= x_in;
      r_ya    <= y_in;
    end
  end

  always_comb begin
    w_x_rot = r_xa;
    w_y_rot = r_ya;
    case (r_q)
      QUAD_0: begin
        w_x_rot = r_xa;
        w_y_rot = r_ya;
      end
      QUAD_1: begin
        w_x_rot = neg_sat(r_ya);
        w_y_rot = r_xa;
      end
      QUAD_2: begin
        w_x_rot = neg_sat(r_xa);
        w_y_rot = neg_sat(r_ya);
      end
      QUAD_3: begin
        w_x_rot = r_ya;
        w_y_rot = neg_sat(r_xa);
      end
      default: begin
        w_x_rot = r_xa;
        w_y_rot = r_ya;
      end
    endcase
  end

`ifdef CORDIC_GAIN_COMP_EN
  assign w_x_b = scale_inv_k(w_x_rot);
  assign w_y_b = scale_inv_k(w_y_rot);
`else
  assign w_x_b = w_x_rot;
  assign w_y_b = w_y_rot;
`endif

  // Residual (2^16 = 2*pi) to Q2.14 radians, rounded half-up.
  assign w_ang_prod = PROD_W'(r_resid) * HALF_PI_Q14 + ANG_ROUND;
  assign w_angle    = WIDTH'(w_ang_prod >>> ANG_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_out <= '0;
      r_y_out <= '0;
      r_angle <= '0;
    end else if (w_fe_pipe[0]) begin
      r_x_out <= w_x_b;
      r_y_out <= w_y_b;
      r_angle <= w_angle;
    end
  end

  cordic_valid_delay #(
    .DEPTH (FE_DEPTH)
  ) u_fe_valid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (in_valid),
    .o_pipe  (w_fe_pipe)
  );

  cordic_valid_delay #(
    .DEPTH (ROT_DEPTH)
  ) u_rot_valid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_fe_pipe[FE_DEPTH-1]),
    .o_pipe  (w_rot_pipe)
  );

  assign x_out     = r_x_out;
  assign y_out     = r_y_out;
  assign angle_out = r_angle;
  assign out_valid = w_fe_pipe[FE_DEPTH-1];
  assign res_valid = w_rot_pipe[ROT_DEPTH-1];
  assign busy      = (|w_fe_pipe) | (|w_rot_pipe);

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// Self-checking bench for cordic_phase_frontend: directed test-plan steps plus randomized traffic vs a cycle-history model.
module tb_cordic_phase_frontend;

  localparam int HMAX = 4096;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic        [15:0] phase_in = '0;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic signed [15:0] angle_out;
  logic               out_valid;
  logic               res_valid;
  logic               busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Input history per clock edge: what was presented and whether reset was high.
  int hv [HMAX];
  int hr [HMAX];
  int hx [HMAX];
  int hy [HMAX];
  int hp [HMAX];
  logic obs_rv [HMAX];
  logic obs_busy [HMAX];

  cordic_phase_frontend #(
    .WIDTH  (16),
    .STAGES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .y_in      (y_in),
    .phase_in  (phase_in),
    .x_out     (x_out),
    .y_out     (y_out),
    .angle_out (angle_out),
    .out_valid (out_valid),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Expected output data for the sample presented at edge s.
  task automatic ref_sample(input int s, output logic [15:0] ex, output logic [15:0] ey,
                            output logic [15:0] ea);
    longint ph, q, r, xs, ys, rx, ry;
    ph = longint'(hp[s]);
    q  = ((ph + 8192) % 65536) / 16384;
    r  = ph - q * 16384;
    if (r >= 32768) r = r - 65536;
    xs = longint'(hx[s]);
    ys = longint'(hy[s]);
    case (q)
      0: begin rx = xs;  ry = ys;  end
      1: begin rx = -ys; ry = xs;  end
      2: begin rx = -xs; ry = -ys; end
      default: begin rx = ys; ry = -xs; end
    endcase
    rx = sat16(rx);
    ry = sat16(ry);
`ifdef CORDIC_GAIN_COMP_EN
    rx = fdiv(rx * 19898 + 16384, 32768);
    ry = fdiv(ry * 19898 + 16384, 32768);
`endif
    ex = 16'(rx);
    ey = 16'(ry);
    ea = 16'(fdiv(r * 25736 + 8192, 16384));
  endtask

  // Present one cycle of inputs, clock it, and compare all outputs to the model.
  task automatic tick(input logic v, input int x, input int y, input int ph, input logic rst);
    logic [15:0] ex, ey, ea;
    logic e_ov, e_rv, e_busy;
    int e;
    reset    = rst;
    in_valid = v;
    x_in     = 16'(x);
    y_in     = 16'(y);
    phase_in = 16'(ph);
    hv[cyc] = int'(v);
    hr[cyc] = int'(rst);
    hx[cyc] = x;
    hy[cyc] = y;
    hp[cyc] = ph & 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    e = cyc;
    ex = '0; ey = '0; ea = '0;
    for (int t = e; t >= 0; t--) begin
      if (hr[t] != 0) break;
      if (t <= e - 1 && hv[t] != 0) begin
        ref_sample(t, ex, ey, ea);
        break;
      end
    end
    e_ov = (e >= 1) && hv[e-1] != 0 && hr[e-1] == 0 && hr[e] == 0;
    e_rv = 1'b0;
    e_busy = 1'b0;
    for (int t = e; t >= 0 && t >= e - 18; t--) begin
      if (hr[t] != 0) break;
      if (hv[t] != 0) begin
        e_busy = 1'b1;
        if (t == e - 18) e_rv = 1'b1;
      end
    end
    chk("x_out", x_out, ex);
    chk("y_out", y_out, ey);
    chk("angle_out", angle_out, ea);
    chk("out_valid", 16'(out_valid), 16'(e_ov));
    chk("res_valid", 16'(res_valid), 16'(e_rv));
    chk("busy", 16'(busy), 16'(e_busy));
    obs_rv[cyc]   = res_valid;
    obs_busy[cyc] = busy;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0, 1'b0);
  endtask

  int c0, c1, rx, ry, rp;
  logic rv_exp;

  initial begin
    @(negedge clk);
    tick(1'b0, 0, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 0, 1'b1);
    chk("rst_x", x_out, 16'h0000);
    chk("rst_angle", angle_out, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    idle(2);

    // Zero phase, pass-through; out_valid exactly two cycles after in_valid.
    tick(1'b1, 16384, 0, 16'h0000, 1'b0);
    chk("zero_ov_early", 16'(out_valid), 16'h0000);
    idle(1);
    chk("zero_ov", 16'(out_valid), 16'h0001);
    idle(1);
    chk("zero_ov_drop", 16'(out_valid), 16'h0000);
`ifndef CORDIC_GAIN_COMP_EN
    chk("zero_x", x_out, 16'd16384);
`endif
    chk("zero_y", y_out, 16'h0000);
    chk("zero_angle", angle_out, 16'h0000);

    tick(1'b1, 16384, 0, 16'h4000, 1'b0);
    idle(2);
    chk("q1_x", x_out, 16'h0000);
`ifndef CORDIC_GAIN_COMP_EN
    chk("q1_y", y_out, 16'd16384);
`endif
    chk("q1_angle", angle_out, 16'h0000);

    tick(1'b1, 16384, 0, 16'h2000, 1'b0);
    idle(2);
    chk("b2000_x", x_out, 16'h0000);
`ifndef CORDIC_GAIN_COMP_EN
    chk("b2000_y", y_out, 16'd16384);
`endif
    chk("b2000_angle", angle_out, 16'(-12868));

    tick(1'b1, 16384, 0, 16'h1FFF, 1'b0);
    idle(2);
`ifndef CORDIC_GAIN_COMP_EN
    chk("b1fff_x", x_out, 16'd16384);
`endif
    chk("b1fff_angle", angle_out, 16'd12866);

    tick(1'b1, 16384, 0, 16'hE000, 1'b0);
    idle(2);
    chk("be000_angle", angle_out, 16'(-12868));

    tick(1'b1, -32768, 0, 16'h8000, 1'b0);
    idle(2);
`ifndef CORDIC_GAIN_COMP_EN
    chk("sat_x", x_out, 16'd32767);
`endif
    chk("sat_y", y_out, 16'h0000);

    tick(1'b1, 32767, 0, 16'h0000, 1'b0);
    idle(2);
`ifdef CORDIC_GAIN_COMP_EN
    chk("gain_x", x_out, 16'd19897);
`else
    chk("gain_x", x_out, 16'd32767);
`endif
    idle(20);

    // Five-sample burst: res_valid on edges 18..22 after the first sampling edge.
    c0 = cyc;
    for (int i = 0; i < 5; i++) tick(1'b1, 1000 * i, -500 * i, 16'h3000 * i, 1'b0);
    idle(25);
    for (int k = 0; k < 28; k++) begin
      rv_exp = (k >= 18 && k <= 22);
      chk("burst_rv", 16'(obs_rv[c0+k]), 16'(rv_exp));
    end

    // Reset mid-burst discards everything in flight.
    c1 = cyc;
    for (int i = 0; i < 5; i++) tick(1'b1, 2000 + i, 3000 - i, 16'h1234 * (i + 1), 1'b0);
    idle(5);
    tick(1'b0, 0, 0, 0, 1'b1);
    idle(25);
    for (int k = 0; k < 36; k++) chk("rstburst_rv", 16'(obs_rv[c1+k]), 16'h0000);
    for (int k = 10; k < 36; k++) chk("rstburst_busy", 16'(obs_busy[c1+k]), 16'h0000);

    // Randomized traffic with extremes, quadrant boundaries and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rx = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      ry = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      case ($urandom_range(0, 5))
        0: rp = 16'h2000 + 16'h4000 * int'($urandom_range(0, 3));
        1: rp = (16'h1FFF + 16'h4000 * int'($urandom_range(0, 3))) & 16'hFFFF;
        default: rp = int'($urandom_range(0, 65535));
      endcase
      tick(($urandom_range(0, 3) != 0), rx, ry, rp, ($urandom_range(0, 59) == 0));
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_phase_frontend.md
# cordic_phase_frontend

Upstream front end for the 16-stage CORDIC rotation pipeline. It accepts a full-circle binary phase and a vector (x, y), and pre-rotates the vector by a multiple of 90° so that the residual angle stays within ±π/4. It then converts that residual to the pipeline's Q2.14 radian angle format. It also tracks sample validity through the CORDIC latency so downstream logic knows when `x_out`/`y_out` of the rotator are meaningful.

## Interface
- `WIDTH`, 16, data/angle width (only 16 supported; constants sized for it)
- `STAGES`, 16, CORDIC stage count; sets the result-valid delay
- `clk`  in  1  rising-edge clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input sample strobe
- `x_in`, `y_in`  in  WIDTH signed  input vector
- `phase_in`  in  WIDTH unsigned  binary phase, 2^WIDTH = 2π
- `x_out`, `y_out`  out  WIDTH signed  pre-rotated vector, goes to the CORDIC `x_in`/`y_in`
- `angle_out`  out  WIDTH signed  residual angle, Q2.14 radians, goes to the CORDIC `angle_in`
- `out_valid`  out  1  `x_out`/`y_out`/`angle_out` hold a new sample
- `res_valid`  out  1  CORDIC outputs correspond to a valid sample
- `busy`  out  1  at least one valid sample is in flight (front end or rotator)

## Operation
- **Stage A** (registered when `in_valid`=1):
  - `p = phase_in + 0x2000` (mod 2^16).
  - `q = p[15:14]`.
  - `r = phase_in − q·0x4000`, signed, in [−0x2000, 0x1FFF].
  - Capture `x_in`, `y_in`.
- **Stage B:**
  - Angle: `angle_out = (r·25736 + 2^13) >>> 14`, where 25736 = π/2 in Q1.14. This gives ±12868 at r = ±0x2000.
  - Rotation by `q`:
    - q=0: (x, y)
    - q=1: (−y, x)
    - q=2: (−x, −y)
    - q=3: (y, −x)
  - Negating −32768 saturates to +32767.
- When `in_valid`=0, the stage registers hold their values and the valid bits clear. The CORDIC keeps recomputing the held values, which is harmless.
- **Valid tracking:** two-bit front-end valid pipe, then a shift register of depth STAGES+1 driving `res_valid`.
- `busy` = OR of all valid bits.
- No backpressure: the rotator is free-running, so a sample is accepted every cycle.

## Timing
- Reset (synchronous, one cycle) zeros all data registers, both valid pipes, and every output; `busy` = 0.
- Latency: `in_valid` at edge N gives `out_valid` after edge N+2 and `res_valid` after edge N+2+STAGES+1 (19 for STAGES=16).
- Throughput: 1 sample per clock; back-to-back samples are never merged or dropped.
- Reset asserted mid-stream discards all in-flight samples. `res_valid` stays 0 until newly accepted samples reach the end of the pipe.
- Phase boundaries:
  - 0x2000 maps to q=1, r=−0x2000.
  - 0x1FFF maps to q=0, r=0x1FFF.
  - 0xE000 maps to q=0, r=−0x2000.
  - All wrap is mod 2^16.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined:
  - Stage B additionally scales the rotated x and y by 1/K: `(v·19898 + 2^14) >>> 15`, where 19898 = 0.60725 in Q1.15.
  - Resulting CORDIC output magnitude equals the input magnitude.
  - Latency is unchanged; the multiply is in the same stage.
- Undefined: x and y pass through unscaled, and the CORDIC output carries gain ≈1.6468.

## Structure
- Shared package `cordic_pkg`:
  - `HALF_PI_Q14` = 25736
  - `INV_K_Q15` = 19898
  - `QUAD_OFFSET` = 0x2000
  - 2-bit quadrant typedef
- One sub-module, `cordic_valid_delay`: parameterised-depth valid shift register with synchronous clear. Instantiated for both the front-end and the rotator delay.

## Test plan
- Zero phase, pass-through (macro off): `phase_in`=0x0000, x=16384, y=0 → `x_out`=16384, `y_out`=0, `angle_out`=0; `out_valid` 2 cycles later.
- 90° phase: `phase_in`=0x4000, x=16384, y=0 → q=1, `x_out`=0, `y_out`=16384, `angle_out`=0.
- Quadrant-boundary phase: `phase_in`=0x2000, x=16384, y=0 → `x_out`=0, `y_out`=16384, `angle_out`=−12868. `phase_in`=0x1FFF → `x_out`=16384, `angle_out`=12866.
- Saturating negation: `phase_in`=0x8000, x=−32768, y=0 → `x_out`=32767, `y_out`=0.
- Gain compensation (macro on): x=32767, y=0, `phase_in`=0 → `x_out`=19897.
- Valid tracking and reset:
  - A 5-sample burst → `res_valid` high exactly on cycles 19–23 after the first `in_valid`.
  - Reset at cycle 10 → `res_valid` and `busy` never assert for that burst.
